// File: rtl/corr_gate_fifo.sv
// Correspondence gate: indexes the frame-0 pixel stream, dispatches depth-valid pixels to a
// fixed-latency projection engine, gates the results and buffers them in a credit-throttled FWFT FIFO.
module corr_gate_fifo #(
  parameter int unsigned H_BW       = 10,
  parameter int unsigned V_BW       = 9,
  parameter int unsigned DEPTH_BW   = 16,
  parameter int unsigned CLOUD_BW   = 32,
  parameter int unsigned PE_LAT     = 11,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_BW     = 20
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_start,
  input  logic                i_frame_end,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DEPTH_BW-1:0] i_depth0,
  input  logic [H_BW-1:0]     r_hsize,
  input  logic [V_BW-1:0]     r_vsize,
  input  logic [DEPTH_BW-1:0] r_min_depth,
  input  logic [DEPTH_BW-1:0] r_max_depth,
  input  logic [V_BW-1:0]     r_max_diff_line,
  output logic                o_pe_valid,
  output logic [H_BW-1:0]     o_pe_idx_x,
  output logic [V_BW-1:0]     o_pe_idx_y,
  output logic [DEPTH_BW-1:0] o_pe_depth,
  input  logic                i_pe_valid,
  input  logic [H_BW-1:0]     i_pe_x,
  input  logic [V_BW-1:0]     i_pe_y,
  input  logic [CLOUD_BW-1:0] i_pe_z,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [H_BW-1:0]     o_idx0_x,
  output logic [V_BW-1:0]     o_idx0_y,
  output logic [H_BW-1:0]     o_idx1_x,
  output logic [V_BW-1:0]     o_idx1_y,
  output logic [DEPTH_BW-1:0] o_depth0,
  output logic [CLOUD_BW-1:0] o_trans_z1,
  output logic                o_frame_done,
  output logic [CNT_BW-1:0]   o_corr_cnt,
  output logic                o_err_sync
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 2;

  typedef struct packed {
    logic                v;
    logic [H_BW-1:0]     x;
    logic [V_BW-1:0]     y;
    logic [DEPTH_BW-1:0] d;
    logic                fe;
  } tag_t;

  typedef struct packed {
    logic [H_BW-1:0]     x0;
    logic [V_BW-1:0]     y0;
    logic [H_BW-1:0]     x1;
    logic [V_BW-1:0]     y1;
    logic [DEPTH_BW-1:0] d;
    logic [CLOUD_BW-1:0] z;
  } ent_t;

  logic [H_BW-1:0]   nx_x;
  logic [V_BW-1:0]   nx_y;
  logic [H_BW-1:0]   pix_x;
  logic [V_BW-1:0]   pix_y;
  logic              accept;
  logic              depth_ok;
  logic              dispatch;
  tag_t              disp_q;
  tag_t              tag_sr [PE_LAT];
  tag_t              tag_out;
  logic [V_BW-1:0]   dy;
  logic              push;
  logic              pop;
  ent_t              mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       fifo_cnt;
  logic [AW:0]       inflight;
  logic [CNT_BW-1:0] frame_cnt;
  logic [CNT_BW-1:0] cnt_next;
  ent_t              head;

  assign accept   = i_valid && o_ready;
  assign pix_x    = i_frame_start ? '0 : nx_x;
  assign pix_y    = i_frame_start ? '0 : nx_y;
  assign depth_ok = (i_depth0 > r_min_depth) && (i_depth0 < r_max_depth);
  assign dispatch = accept && depth_ok;

  assign o_pe_valid = disp_q.v;
  assign o_pe_idx_x = disp_q.x;
  assign o_pe_idx_y = disp_q.y;
  assign o_pe_depth = disp_q.d;

  assign tag_out = tag_sr[PE_LAT-1];
  assign dy      = (i_pe_y >= tag_out.y) ? (i_pe_y - tag_out.y) : (tag_out.y - i_pe_y);
  assign push    = tag_out.v && (i_pe_x < r_hsize) && (i_pe_y < r_vsize) && (dy <= r_max_diff_line);

  assign o_valid = (fifo_cnt != '0);
  assign pop     = o_valid && i_ready;
  assign head    = mem[rptr];
  assign o_idx0_x   = head.x0;
  assign o_idx0_y   = head.y0;
  assign o_idx1_x   = head.x1;
  assign o_idx1_y   = head.y1;
  assign o_depth0   = head.d;
  assign o_trans_z1 = head.z;

  // Credits cover every valid pixel between dispatch and FIFO entry, so a full FIFO can never overflow.
  assign o_ready  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < CW'(FIFO_DEPTH);
  assign cnt_next = (push && (frame_cnt != '1)) ? frame_cnt + CNT_BW'(1) : frame_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nx_x   <= '0;
      nx_y   <= '0;
      disp_q <= '0;
      for (int unsigned i = 0; i < PE_LAT; i++) tag_sr[i] <= '0;
    end else begin
      disp_q <= '0;
      if (accept) begin
        disp_q.v  <= depth_ok;
        disp_q.x  <= pix_x;
        disp_q.y  <= pix_y;
        disp_q.d  <= i_depth0;
        disp_q.fe <= i_frame_end;
        if (pix_x == r_hsize - H_BW'(1)) begin
          nx_x <= '0;
          nx_y <= (pix_y == r_vsize - V_BW'(1)) ? '0 : pix_y + V_BW'(1);
        end else begin
          nx_x <= pix_x + H_BW'(1);
          nx_y <= pix_y;
        end
      end
      tag_sr[0] <= disp_q;
      for (int unsigned i = 1; i < PE_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{x0: tag_out.x, y0: tag_out.y, x1: i_pe_x, y1: i_pe_y, d: tag_out.d, z: i_pe_z};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({dispatch, tag_out.v})
        2'b10:   inflight <= inflight + (AW+1)'(1);
        2'b01:   inflight <= inflight - (AW+1)'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt    <= '0;
      o_corr_cnt   <= '0;
      o_frame_done <= 1'b0;
      o_err_sync   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (tag_out.fe) begin
        o_corr_cnt   <= cnt_next;
        frame_cnt    <= '0;
        o_frame_done <= 1'b1;
      end else begin
        frame_cnt <= cnt_next;
      end
      if (i_pe_valid != tag_out.v) o_err_sync <= 1'b1;
    end
  end

endmodule

// File: doc/corr_gate_fifo.md
Name: corr_gate_fifo

Overview:
- Parametrised correspondence front/back end for the direct RGB-D odometry path.
- Accepts the frame-0 pixel stream and generates pixel indices. Depth-valid pixels are dispatched to an external fixed-latency projection engine (cloud -> pose transform -> projection).
- Projection results are gated against runtime image bounds and vertical disparity limits, then buffered in an output FIFO with valid/ready backpressure.
- Supersedes the fixed 640x480 unbuffered gate; adds credit-based input throttling and a per-frame correspondence count.

Parameters:
- H_BW, 10, horizontal index width
- V_BW, 9, vertical index width
- DEPTH_BW, 16, depth sample width
- CLOUD_BW, 32, transformed-z width
- PE_LAT, 11, projection engine latency in cycles (o_pe_valid -> i_pe_valid), >=1
- FIFO_DEPTH, 16, output FIFO entries, power of 2, >=4
- CNT_BW, 20, correspondence counter width (saturating)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_frame_start  in  1  qualifies first pixel of frame
- i_frame_end  in  1  qualifies last pixel of frame
- i_valid  in  1  input pixel valid
- o_ready  out  1  input accept; a beat transfers when i_valid && o_ready
- i_depth0  in  DEPTH_BW  frame-0 depth sample
- r_hsize  in  H_BW  image width
- r_vsize  in  V_BW  image height
- r_min_depth  in  DEPTH_BW  exclusive lower depth bound
- r_max_depth  in  DEPTH_BW  exclusive upper depth bound
- r_max_diff_line  in  V_BW  max |proj_y - idx0_y|
- o_pe_valid  out  1  dispatch to projection engine
- o_pe_idx_x  out  H_BW  dispatched x
- o_pe_idx_y  out  V_BW  dispatched y
- o_pe_depth  out  DEPTH_BW  dispatched depth
- i_pe_valid  in  1  projection result valid
- i_pe_x  in  H_BW  projected x (unsigned; out-of-image values are >= r_hsize)
- i_pe_y  in  V_BW  projected y
- i_pe_z  in  CLOUD_BW  transformed z
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accept
- o_idx0_x  out  H_BW  source x
- o_idx0_y  out  V_BW  source y
- o_idx1_x  out  H_BW  projected x
- o_idx1_y  out  V_BW  projected y
- o_depth0  out  DEPTH_BW  source depth
- o_trans_z1  out  CLOUD_BW  transformed z
- o_frame_done  out  1  one-cycle pulse, frame fully projected
- o_corr_cnt  out  CNT_BW  correspondences pushed in the last completed frame
- o_err_sync  out  1  sticky: i_pe_valid disagrees with the expected dispatch tag

Behaviour:
- Reset i_rst_n, asynchronous, active-low; clock i_clk. All registers clear.
  - Reset values: o_pe_valid=0, o_valid=0, o_frame_done=0, o_corr_cnt=0, o_err_sync=0, all data outputs 0.
  - o_ready=1 after reset, because FIFO count and in-flight count are both 0.
- Accept = i_valid && o_ready.
- Index counters:
  - On accept, x increments; at x==r_hsize-1 it wraps to 0 and y increments; at y==r_vsize-1 it wraps to 0.
  - i_frame_start on an accepted beat forces that pixel's index to (0,0); the next pixel is (1,0).
- Dispatch (registered, 1 cycle):
  - o_pe_valid=1 iff accepted && r_min_depth < i_depth0 < r_max_depth.
  - The pixel's index is driven on o_pe_idx_x/y whether or not depth is valid.
  - Invalid-depth pixels still advance the index.
- Tag pipeline: PE_LAT-stage shift register carries {pe_valid, idx_x, idx_y, depth, frame_end} for every accepted beat and for bubbles (bubble tag = all 0).
- Sync check: i_pe_valid != tag valid at the tag output sets o_err_sync. It clears only on reset.
- Gate: push when tag valid && i_pe_x < r_hsize && i_pe_y < r_vsize && |i_pe_y - tag_y| <= r_max_diff_line.
  - The difference is computed unsigned with the larger minus the smaller, so there is no wrap.
- Push is registered into the FIFO, which is first-word-fall-through.
- Latency, empty FIFO: accept at cycle t -> o_valid at t+2+PE_LAT.
- Credits:
  - inflight += on dispatch of a valid pixel; inflight -= at tag-exit of a valid pixel, whether or not it is pushed.
  - o_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registers only.
  - The FIFO therefore never overflows.
  - Simultaneous dispatch and exit leaves inflight unchanged.
- FIFO:
  - Pop when o_valid && i_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Output data holds while o_valid && !i_ready.
  - Pop on empty is ignored.
- Frame count:
  - The per-frame counter increments per push and saturates at 2^CNT_BW-1.
  - When a frame_end tag exits, o_frame_done pulses the next cycle. o_corr_cnt latches the count including that pixel's push, and the counter clears.
  - If a push coincides with the frame_end exit, the push is included in that frame's count.
- i_frame_start has no effect beyond the index reset. Frame boundaries for counting are defined solely by the frame_end tag.

Test Plan:
- 4x2 frame, depths all 1000, bounds (0,4000), identity PE model (proj = idx) -> 8 FIFO entries in raster order (0,0)..(3,1); o_frame_done one cycle after the last tag exit; o_corr_cnt=8.
- Depths alternating 0/1000 -> only odd-x pixels dispatched; indices still advance; o_corr_cnt=4; inflight never exceeds the number of valid pixels.
- PE model shifts y by +3, r_max_diff_line=2 -> nothing pushed. With r_max_diff_line=3 -> all in-bounds pixels (y+3<r_vsize) pushed.
- PE returns x=r_hsize for every pixel -> no pushes, o_corr_cnt=0, o_frame_done still pulses.
- i_ready=0 with FIFO_DEPTH=4, PE_LAT=11, continuous input -> o_ready drops after 4 valid dispatches; no FIFO entry is lost; releasing i_ready drains entries in order.
- Inject i_pe_valid=1 at a bubble tag -> o_err_sync=1, holding; assert i_rst_n low mid-frame -> all outputs 0, index (0,0), o_ready=1.
